led_fade_chaser: RTL
====================

# led_fade_chaser

Drives the five Icestick user LEDs D1..D5 with PWM-faded patterns: a triangle-wave brightness ramp that either bounces a single fading LED back and forth ("chase" mode) or breathes all five together ("breathe" mode). It sits directly downstream of the free-running timebase counter, which supplies a one-cycle step strobe. This block replaces raw counter bits on the LED pins with smooth, visible fades.

## Interface
- PWM_BITS, 8: width of the PWM counter, brightness ramp and duty values; MAX = 2^PWM_BITS-1.
- STEP, 16: ramp increment/decrement per tick; legal range 1..MAX.
- CLK_i  input  1  system clock (12 MHz on Icestick).
- RST_i  input  1  reset. Synchronous, active-high; one clock; all state is in the CLK_i domain.
- tick_i  input  1  ramp step strobe from the upstream timebase; one cycle high per step; held high means a step every cycle.
- mode_i  input  1  0 = chase, 1 = breathe; sampled every cycle.
- D1, D2, D3, D4, D5  output  1 each  LED drives, registered, active-high.

## Operation
- pwm_cnt (PWM_BITS): increments every clock, wraps MAX→0, not gated by tick_i.
- ramp (PWM_BITS) and ramp_dir (up/down) update only on cycles with tick_i=1:
  - up: if ramp > MAX-STEP then ramp=MAX, ramp_dir=down; else ramp += STEP.
  - down: if ramp < STEP then ramp=0, ramp_dir=up; else ramp -= STEP.
  - All compares are unsigned at PWM_BITS width; no intermediate overflow is permitted (compare before add).
- wrap event: the tick on which the down branch sets ramp=0.
- pos (0..4) and pos_dir (right/left) update only on a wrap event while mode_i=0:
  - right: pos==4 → pos=3, pos_dir=left; else pos+1.
  - left: pos==0 → pos=1, pos_dir=right; else pos-1.
  - Sequence: 0,1,2,3,4,3,2,1,0,1,...
- While mode_i=1, pos and pos_dir are frozen. The ramp keeps running in both modes.
- duty_k (k = 0..4 for D1..D5):
  - chase: duty_k = ramp if k==pos, else 0.
  - breathe: duty_k = ramp for all k.
- D(k+1) is registered from the comparison (pwm_cnt < duty_k). duty 0 gives an LED that is always off; duty MAX gives an LED that is on MAX of every MAX+1 cycles.
- A mode change needs no resynchronisation. The new duty mapping is used from the next cycle, and ramp, pos and pwm_cnt are not disturbed.

## Timing
- Reset (RST_i high at a clock edge) sets: pwm_cnt=0, ramp=0, ramp_dir=up, pos=0, pos_dir=right, D1..D5=0. RST_i has priority over tick_i on the same edge.
- Reset mid-ramp or mid-chase aborts immediately; no partial step is retained.
- First cycle after reset release: pwm_cnt=0 and duty=0, so all LEDs remain 0.
- Output latency: D reflects pwm_cnt and duty sampled on the previous edge, i.e. one cycle.
- Ramp/pos update: the new value is visible in registers one edge after the tick_i cycle. It affects D one further cycle later.
- With defaults, the ramp up-sequence per tick is 0,16,...,240,255 (16 ticks), then 239,...,15,0 (16 ticks). Period is 32 ticks; pos advances once per 32 ticks.
- tick_i held high continuously: legal; the ramp steps every cycle.

## Test plan
- Reset: hold RST_i 3 cycles with tick_i=1 and mode_i=1 → D1..D5=0 throughout and on the first cycle after release; ramp=0, pos=0.
- Ramp shape: mode_i=1, issue 32 isolated ticks → ramp follows 0,16,...,240,255,239,...,15,0. ramp_dir flips exactly at 255 and at 0.
- PWM duty: freeze ramp at 64 (no ticks), mode_i=1 → each of D1..D5 high exactly 64 of every 256 cycles. Repeat at ramp=255 → 255/256 high; at ramp=0 → never high.
- Chase bounce: mode_i=0, tick_i held high for 9×32 cycles → pos sequence 0,1,2,3,4,3,2,1,0,1. In each period only D(pos+1) ever goes high.
- Mode switch: switch mode_i 0→1 with pos=2 and ramp=128 → from the next cycle all five LEDs share duty 128. pos stays 2 across subsequent wraps. Switching back resumes the chase from pos=2 in the same direction.
- Reset mid-operation: assert RST_i one cycle at pos=3, ramp=200, with a coincident tick → next state pos=0, ramp=0, ramp_dir=up, pos_dir=right, D=0.

Source files
------------

// File: rtl/led_fade_chaser.sv
// ---------------------------------------------------------------------------
// led_fade_chaser
//
// Drives the five Icestick user LEDs with PWM-faded patterns. A triangle-wave
// brightness ramp steps once per tick_i strobe. In chase mode (mode_i=0) a
// single LED carries the ramp and the lit position bounces 0..4..0, advancing
// once per full ramp period. In breathe mode (mode_i=1) all five LEDs carry
// the ramp together and the chase position is frozen.
//
// Ports
//   CLK_i   system clock
//   RST_i   synchronous active-high reset
//   tick_i  one-cycle ramp step strobe (held high = step every cycle)
//   mode_i  0 = chase, 1 = breathe; sampled every cycle
//   D1..D5  registered active-high LED drives
// ---------------------------------------------------------------------------
module led_fade_chaser #(
  parameter int PWM_BITS = 8,
  parameter int STEP     = 16
) (
  input  logic CLK_i,
  input  logic RST_i,
  input  logic tick_i,
  input  logic mode_i,
  output logic D1,
  output logic D2,
  output logic D3,
  output logic D4,
  output logic D5
);

  localparam logic [PWM_BITS-1:0] MAX_V    = {PWM_BITS{1'b1}};
  localparam logic [PWM_BITS-1:0] STEP_V   = PWM_BITS'(STEP);
  // Highest ramp value that can still take a full upward step without
  // overflowing; compared before adding so no carry is ever produced.
  localparam logic [PWM_BITS-1:0] UP_LIMIT = MAX_V - STEP_V;

  typedef enum logic {
    RAMP_UP   = 1'b0,
    RAMP_DOWN = 1'b1
  } ramp_dir_t;

  typedef enum logic {
    POS_RIGHT = 1'b0,
    POS_LEFT  = 1'b1
  } pos_dir_t;

  // State registers
  logic [PWM_BITS-1:0] r_pwm_cnt;
  logic [PWM_BITS-1:0] r_ramp;
  ramp_dir_t           r_ramp_dir;
  logic [2:0]          r_pos;
  pos_dir_t            r_pos_dir;
  logic [4:0]          r_led;

  // Next-state and datapath wires
  logic [PWM_BITS-1:0] w_ramp_nxt;
  ramp_dir_t           w_ramp_dir_nxt;
  logic                w_wrap;
  logic [2:0]          w_pos_nxt;
  pos_dir_t            w_pos_dir_nxt;
  logic [PWM_BITS-1:0] w_duty [5];
  logic [4:0]          w_led_nxt;

  // Triangle ramp: clamps to MAX at the top and to 0 at the bottom, turning
  // around on the clamp. Reaching 0 on the way down is the wrap event.
  always_comb begin
    // NOTE: every signal driven here gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    w_ramp_nxt     = r_ramp;
    w_ramp_dir_nxt = r_ramp_dir;
    w_wrap         = 1'b0;
    if (tick_i) begin
      unique case (r_ramp_dir)
        RAMP_UP: begin
          if (r_ramp > UP_LIMIT) begin
            w_ramp_nxt     = MAX_V;
            w_ramp_dir_nxt = RAMP_DOWN;
          end else begin
            w_ramp_nxt = r_ramp + STEP_V;
          end
        end
        RAMP_DOWN: begin
          if (r_ramp < STEP_V) begin
            w_ramp_nxt     = '0;
            w_ramp_dir_nxt = RAMP_UP;
            w_wrap         = 1'b1;
          end else begin
            w_ramp_nxt = r_ramp - STEP_V;
          end
        end
        default: ;
      endcase
    end
  end

  // Chase position bounces between the end LEDs, moving once per wrap while
  // in chase mode; breathe mode leaves it untouched.
  always_comb begin
    w_pos_nxt     = r_pos;
    w_pos_dir_nxt = r_pos_dir;
    if (w_wrap && !mode_i) begin
      unique case (r_pos_dir)
        POS_RIGHT: begin
          if (r_pos == 3'd4) begin
            w_pos_nxt     = 3'd3;
            w_pos_dir_nxt = POS_LEFT;
          end else begin
            w_pos_nxt = r_pos + 3'd1;
          end
        end
        POS_LEFT: begin
          if (r_pos == 3'd0) begin
            w_pos_nxt     = 3'd1;
            w_pos_dir_nxt = POS_RIGHT;
          end else begin
            w_pos_nxt = r_pos - 3'd1;
          end
        end
        default: ;
      endcase
    end
  end

  // Duty mapping uses the live mode_i, so a mode change takes effect on the
  // very next registered LED value without disturbing ramp or position.
  always_comb begin
    w_led_nxt = '0;
    for (int k = 0; k < 5; k++) begin
      w_duty[k]    = (mode_i || (r_pos == 3'(k))) ? r_ramp : '0;
      w_led_nxt[k] = (r_pwm_cnt < w_duty[k]);
    end
  end

  always_ff @(posedge CLK_i) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (RST_i) begin
      r_pwm_cnt  <= '0;
      r_ramp     <= '0;
      r_ramp_dir <= RAMP_UP;
      r_pos      <= 3'd0;
      r_pos_dir  <= POS_RIGHT;
      r_led      <= '0;
    end else begin
      r_pwm_cnt  <= r_pwm_cnt + PWM_BITS'(1);
      r_ramp     <= w_ramp_nxt;
      r_ramp_dir <= w_ramp_dir_nxt;
      r_pos      <= w_pos_nxt;
      r_pos_dir  <= w_pos_dir_nxt;
      r_led      <= w_led_nxt;
    end
  end

  assign D1 = r_led[0];
  assign D2 = r_led[1];
  assign D3 = r_led[2];
  assign D4 = r_led[3];
  assign D5 = r_led[4];

endmodule
